// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry, pixel coordinate/colour types and fill FSM states.
package vga_pkg;

  localparam int unsigned FB_W_DEF   = 640;
  localparam int unsigned FB_H_DEF   = 480;
  localparam int unsigned ADDR_W_DEF = 19;
  localparam int unsigned PX_X_W     = 10;
  localparam int unsigned PX_Y_W     = 9;
  localparam int unsigned RGB_W      = 24;

  typedef logic [PX_X_W-1:0] px_x_t;
  typedef logic [PX_Y_W-1:0] px_y_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} fill_state_t;

endpackage

// File: rtl/fill_addr_gen.sv
// Row-major pixel walker for one clipped rectangle; the row base is carried
// incrementally so no multiplier is needed while filling.
module fill_addr_gen
  import vga_pkg::*;
#(
  parameter int unsigned FB_W   = FB_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic [PX_X_W-1:0] x0,
  input  logic [PX_Y_W-1:0] y0,
  input  logic [PX_X_W-1:0] x1,
  input  logic [PX_Y_W-1:0] y1,
  input  logic [ADDR_W-1:0] base_init,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  px_x_t             x, x0_q, x1_q;
  px_y_t             y, y1_q;
  logic [ADDR_W-1:0] row_base;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x        <= '0;
      y        <= '0;
      x0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      row_base <= '0;
    end else if (load) begin
      x        <= x0;
      y        <= y0;
      x0_q     <= x0;
      x1_q     <= x1;
      y1_q     <= y1;
      row_base <= base_init;
    end else if (step) begin
      if (x == x1_q) begin
        x        <= x0_q;
        y        <= y + px_y_t'(1);
        row_base <= row_base + ADDR_W'(FB_W);
      end else begin
        x <= x + px_x_t'(1);
      end
    end
  end

  assign addr = row_base + ADDR_W'(x);
  assign last = (x == x1_q) && (y == y1_q);

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: accepts one fill command at a time, clips it to the
// frame buffer and streams one registered pixel write per available slot.
module rect_fill_engine
  import vga_pkg::*;
#(
  parameter int unsigned FB_W        = FB_W_DEF,
  parameter int unsigned FB_H        = FB_H_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter bit          VBLANK_ONLY = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vblank,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [PX_X_W-1:0] cmd_x0,
  input  logic [PX_Y_W-1:0] cmd_y0,
  input  logic [PX_X_W-1:0] cmd_x1,
  input  logic [PX_Y_W-1:0] cmd_y1,
  input  logic [RGB_W-1:0]  cmd_rgb,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [RGB_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam px_x_t X_MAX = px_x_t'(FB_W - 1);
  localparam px_x_t X_LIM = px_x_t'(FB_W);
  localparam px_y_t Y_MAX = px_y_t'(FB_H - 1);
  localparam px_y_t Y_LIM = px_y_t'(FB_H);

  fill_state_t       state_q, state_d;
  px_x_t             x0_q, x1_q, x1_clamp_c;
  px_y_t             y0_q, y1_q, y1_clamp_c;
  rgb_t              rgb_q;
  logic              accept_c, reject_c, slot_c, load_c, step_c, last_c;
  logic [ADDR_W-1:0] base_init_c, addr_c;
  logic              cmd_ready_d, wr_en_d, busy_d, done_d, err_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [RGB_W-1:0]  wr_data_d;

  assign accept_c = cmd_valid & cmd_ready;
  assign slot_c   = !VBLANK_ONLY || vblank;

  // Command capture; cmd_ready is only high in IDLE, so this never overwrites a live command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0_q  <= '0;
      y0_q  <= '0;
      x1_q  <= '0;
      y1_q  <= '0;
      rgb_q <= '0;
    end else if (accept_c) begin
      x0_q  <= cmd_x0;
      y0_q  <= cmd_y0;
      x1_q  <= cmd_x1;
      y1_q  <= cmd_y1;
      rgb_q <= rgb_t'(cmd_rgb);
    end
  end

  // Clip far corner to the frame, then reject empty or off-screen rectangles.
  assign x1_clamp_c  = (x1_q > X_MAX) ? X_MAX : x1_q;
  assign y1_clamp_c  = (y1_q > Y_MAX) ? Y_MAX : y1_q;
  assign reject_c    = (x0_q >= X_LIM) || (y0_q >= Y_LIM) ||
                       (x0_q > x1_clamp_c) || (y0_q > y1_clamp_c);
  assign base_init_c = ADDR_W'(y0_q) * ADDR_W'(FB_W);

  fill_addr_gen #(
    .FB_W   (FB_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load_c),
    .step      (step_c),
    .x0        (x0_q),
    .y0        (y0_q),
    .x1        (x1_clamp_c),
    .y1        (y1_clamp_c),
    .base_init (base_init_c),
    .addr      (addr_c),
    .last      (last_c)
  );

  always_comb begin
    state_d   = state_q;
    load_c    = 1'b0;
    step_c    = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    err_d     = 1'b0;
    case (state_q)
      IDLE: if (accept_c) state_d = CLIP;
      CLIP: begin
        if (reject_c) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          load_c  = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (slot_c) begin
          step_c    = 1'b1;
          wr_en_d   = 1'b1;
          wr_addr_d = addr_c;
          wr_data_d = rgb_q;
          if (last_c) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status outputs track the state being entered so they line up with it once registered.
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cmd_ready <= 1'b1;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= cmd_ready_d;
      wr_en     <= wr_en_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: two instances (free-running and vblank-gated)
// share one command stream; every write is checked against a queued model.
module tb_rect_fill_engine;

  localparam int unsigned AW = 19;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [23:0]   data;
  } wr_t;

  typedef struct {
    int          x0, y0, x1, y1;
    logic [23:0] rgb;
    bit          exp_err;
    int          exp_n;
    int          exp_last;
  } vec_t;

  logic        clk;
  logic        reset_n, vblank, cmd_valid;
  logic [9:0]  cmd_x0, cmd_x1;
  logic [8:0]  cmd_y0, cmd_y1;
  logic [23:0] cmd_rgb;

  logic          cmd_ready [2];
  logic          wr_en     [2];
  logic [AW-1:0] wr_addr   [2];
  logic [23:0]   wr_data   [2];
  logic          busy      [2];
  logic          done      [2];
  logic          err       [2];

  wr_t           q0[$];
  wr_t           q1[$];
  int            tests, fails, cyc_n, acc_cyc;
  int            cnt_wr[2], cnt_done[2], cnt_err[2], first_cyc[2], ev_snap[2];
  logic [AW-1:0] last_addr[2];
  bit            first_pend[2];
  logic          vb_prev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rect_fill_engine #(.FB_W(640), .FB_H(480), .ADDR_W(AW), .VBLANK_ONLY(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .vblank(vblank), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_rgb(cmd_rgb),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  rect_fill_engine #(.FB_W(640), .FB_H(480), .ADDR_W(AW), .VBLANK_ONLY(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .vblank(vblank), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_rgb(cmd_rgb),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: observe outputs on the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    cyc_n++;
    for (int d = 0; d < 2; d++) begin
      if (wr_en[d]) begin
        if (d == 1) chk("slot_in_vblank", 64'(vb_prev), 64'(1));
        if (first_pend[d]) begin
          first_pend[d] = 1'b0;
          first_cyc[d]  = cyc_n;
        end
        cnt_wr[d]++;
        last_addr[d] = wr_addr[d];
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          tests++;
          fails++;
          $display("FAIL extra_write dut%0d: got write at addr %0d expected none", d, wr_addr[d]);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk("wr_addr", 64'(wr_addr[d]), 64'(e.addr));
          chk("wr_data", 64'(wr_data[d]), 64'(e.data));
        end
      end
      if (done[d]) cnt_done[d]++;
      if (err[d])  cnt_err[d]++;
    end
    vb_prev = vblank;
    @(posedge clk);
    #1;
  endtask

  // Reference model: clip, reject, then enumerate row-major addresses.
  task automatic push_rect(input int x0, input int y0, input int x1, input int y1,
                           input logic [23:0] rgb, input int max_n);
    int  cx1, cy1, n;
    wr_t e;
    cx1 = (x1 > 639) ? 639 : x1;
    cy1 = (y1 > 479) ? 479 : y1;
    n   = 0;
    if (x0 >= 640 || y0 >= 480 || x0 > cx1 || y0 > cy1) return;
    for (int y = y0; y <= cy1; y++) begin
      for (int x = x0; x <= cx1; x++) begin
        if (n < max_n) begin
          e.addr = AW'(y * 640 + x);
          e.data = rgb;
          q0.push_back(e);
          q1.push_back(e);
        end
        n++;
      end
    end
  endtask

  task automatic send(input int x0, input int y0, input int x1, input int y1, input logic [23:0] rgb);
    int w;
    w = 0;
    while (!(cmd_ready[0] && cmd_ready[1]) && w < 100) begin
      tick();
      w++;
    end
    if (w >= 100) begin
      tests++;
      fails++;
      $display("FAIL send_ready: got cmd_ready low expected high within 100 cycles");
    end
    for (int d = 0; d < 2; d++) begin
      ev_snap[d]    = cnt_done[d] + cnt_err[d];
      first_pend[d] = 1'b1;
    end
    cmd_x0    = 10'(x0);
    cmd_y0    = 9'(y0);
    cmd_x1    = 10'(x1);
    cmd_y1    = 9'(y1);
    cmd_rgb   = rgb;
    cmd_valid = 1'b1;
    tick();
    acc_cyc   = cyc_n;
    cmd_valid = 1'b0;
    // Scramble inputs after acceptance; the engine must keep its latched copy.
    cmd_x0    = 10'($urandom);
    cmd_y0    = 9'($urandom);
    cmd_x1    = 10'($urandom);
    cmd_y1    = 9'($urandom);
    cmd_rgb   = 24'($urandom);
  endtask

  task automatic wait_end(input int budget, input bit toggle);
    int n;
    n = 0;
    while (((cnt_done[0] + cnt_err[0]) == ev_snap[0] || (cnt_done[1] + cnt_err[1]) == ev_snap[1])
           && n < budget) begin
      tick();
      if (toggle) vblank = ($urandom_range(0, 3) != 0);
      n++;
    end
    vblank = 1'b1;
    if (n >= budget) begin
      tests++;
      fails++;
      $display("FAIL wait_end: got no done/err expected one within %0d cycles", budget);
    end
  endtask

  initial begin
    vec_t vecs[8];
    int   ws[2], ds[2], es[2];

    vecs[0] = '{10, 5, 13, 6, 24'hFF0000, 1'b0, 8, 3853};
    vecs[1] = '{639, 479, 639, 479, 24'h00FF00, 1'b0, 1, 307199};
    vecs[2] = '{630, 470, 700, 500, 24'h0000FF, 1'b0, 100, 307199};
    vecs[3] = '{20, 0, 10, 0, 24'h111111, 1'b1, 0, 0};
    vecs[4] = '{640, 0, 700, 0, 24'h222222, 1'b1, 0, 0};
    vecs[5] = '{0, 480, 5, 500, 24'h333333, 1'b1, 0, 0};
    vecs[6] = '{0, 10, 0, 9, 24'h444444, 1'b1, 0, 0};
    vecs[7] = '{100, 200, 131, 203, 24'h123456, 1'b0, 128, 130051};

    reset_n   = 1'b0;
    vblank    = 1'b1;
    vb_prev   = 1'b1;
    cmd_valid = 1'b0;
    cmd_x0    = '0;
    cmd_y0    = '0;
    cmd_x1    = '0;
    cmd_y1    = '0;
    cmd_rgb   = '0;
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_cmd_ready", 64'(cmd_ready[d]), 64'(1));
      chk("rst_wr_en",     64'(wr_en[d]),     64'(0));
      chk("rst_busy",      64'(busy[d]),      64'(0));
      chk("rst_done",      64'(done[d]),      64'(0));
    end
    reset_n = 1'b1;
    repeat (2) tick();

    // Table-driven commands, vblank held high
    for (int i = 0; i < 8; i++) begin
      for (int d = 0; d < 2; d++) begin
        ws[d] = cnt_wr[d];
        ds[d] = cnt_done[d];
        es[d] = cnt_err[d];
      end
      push_rect(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].rgb, 1 << 30);
      send(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].rgb);
      wait_end(2000, 1'b0);
      repeat (3) tick();
      for (int d = 0; d < 2; d++) begin
        chk("n_writes",    64'(cnt_wr[d] - ws[d]),   64'(vecs[i].exp_n));
        chk("done_pulses", 64'(cnt_done[d] - ds[d]), 64'(vecs[i].exp_err ? 0 : 1));
        chk("err_pulses",  64'(cnt_err[d] - es[d]),  64'(vecs[i].exp_err));
        if (!vecs[i].exp_err) begin
          chk("last_addr", 64'(last_addr[d]), 64'(vecs[i].exp_last));
          // issued two cycles after the accepting edge, visible one registered cycle later
          chk("first_wr_latency", 64'(first_cyc[d] - acc_cyc), 64'(3));
        end
        chk("busy_after", 64'(busy[d]),      64'(0));
        chk("ready_after", 64'(cmd_ready[d]), 64'(1));
      end
      chk("queue_drained", 64'(q0.size() + q1.size()), 64'(0));
    end

    // Reject timing: err and cmd_ready return together two cycles after accept
    send(20, 0, 10, 0, 24'hABCDEF);
    for (int d = 0; d < 2; d++) begin
      chk("clip_ready", 64'(cmd_ready[d]), 64'(0));
      chk("clip_busy",  64'(busy[d]),      64'(1));
      chk("clip_err",   64'(err[d]),       64'(0));
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("rej_err",   64'(err[d]),       64'(1));
      chk("rej_ready", 64'(cmd_ready[d]), 64'(1));
      chk("rej_busy",  64'(busy[d]),      64'(0));
    end
    tick();
    for (int d = 0; d < 2; d++) chk("rej_err_pulse", 64'(err[d]), 64'(0));

    // Full-width band with vblank toggling: gated engine must pause and resume in place
    for (int d = 0; d < 2; d++) begin
      ws[d] = cnt_wr[d];
      ds[d] = cnt_done[d];
    end
    push_rect(0, 0, 639, 11, 24'h5A5A5A, 1 << 30);
    send(0, 0, 639, 11, 24'h5A5A5A);
    wait_end(40000, 1'b1);
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("band_writes", 64'(cnt_wr[d] - ws[d]),   64'(7680));
      chk("band_last",   64'(last_addr[d]),        64'(7679));
      chk("band_done",   64'(cnt_done[d] - ds[d]), 64'(1));
    end
    chk("band_queue", 64'(q0.size() + q1.size()), 64'(0));

    // Reset in the middle of a full-frame fill, then a clean 2x2 command
    for (int d = 0; d < 2; d++) ws[d] = cnt_wr[d];
    push_rect(0, 0, 639, 479, 24'hC0FFEE, 60);
    send(0, 0, 639, 479, 24'hC0FFEE);
    for (int n = 0; n < 500 && (cnt_wr[1] - ws[1]) < 50; n++) tick();
    chk("pre_reset_writes", 64'(cnt_wr[1] - ws[1]), 64'(50));
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("mid_rst_cmd_ready", 64'(cmd_ready[d]), 64'(1));
      chk("mid_rst_wr_en",     64'(wr_en[d]),     64'(0));
      chk("mid_rst_wr_addr",   64'(wr_addr[d]),   64'(0));
      chk("mid_rst_wr_data",   64'(wr_data[d]),   64'(0));
      chk("mid_rst_busy",      64'(busy[d]),      64'(0));
      chk("mid_rst_done",      64'(done[d]),      64'(0));
      chk("mid_rst_err",       64'(err[d]),       64'(0));
    end
    q0.delete();
    q1.delete();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      ws[d] = cnt_wr[d];
      ds[d] = cnt_done[d];
    end
    push_rect(3, 4, 4, 5, 24'h0F0F0F, 1 << 30);
    send(3, 4, 4, 5, 24'h0F0F0F);
    wait_end(200, 1'b0);
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("post_rst_writes", 64'(cnt_wr[d] - ws[d]),   64'(4));
      chk("post_rst_last",   64'(last_addr[d]),        64'(3204));
      chk("post_rst_done",   64'(cnt_done[d] - ds[d]), 64'(1));
    end
    chk("post_rst_queue", 64'(q0.size() + q1.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
